rv32_wishbone_master: RTL and testbench

- Bus master for the memory stage's peripheral window (address[31:28] = 4'h2).
- Converts one load/store request per instruction into a single Wishbone B4 classic cycle.
- Holds the pipeline through the memory stage's stall input while the cycle is in flight.
- Returns load data on the memory stage's wishbone read-data input; sits beside the memory stage, fed from execute/memory-stage-1 signals.

---
 rtl/rv32_wishbone_master_pkg.sv | 16 +
 rtl/rv32_wishbone_master.sv | 126 ++++++++++++
 tb/tb_rv32_wishbone_master.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32_wishbone_master_pkg.sv
// Shared constants and state encoding for the peripheral-window Wishbone master.
package rv32_wishbone_master_pkg;

  // Top address nibble of the peripheral window served by this master.
  localparam logic [3:0] WB_REGION = 4'h2;

  // Default number of BUS-state cycles before an unanswered cycle is aborted.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_BUS,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/rv32_wishbone_master.sv
// Single-cycle Wishbone B4 classic master for memory-stage loads/stores to the
// peripheral window. Stalls the pipeline while the cycle is in flight and
// returns registered load data that stays valid until the next load completes.
module rv32_wishbone_master
  import rv32_wishbone_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_sel_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        bus_error_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  wb_state_t            state, state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [29:0]          adr_word;
  logic                 we_q;
  logic                 timeout_hit;
  logic                 term_ok;
  logic                 term_err;

  // Byte offset is carried by wb_sel_o; the word address drops it.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[1:0];

  assign wb_adr_o    = {adr_word, 2'b00};
  assign timeout_hit = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // State register; async reset abandons any cycle in flight at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= WB_IDLE;
    else       state <= state_next;
  end

  // Next state, bus strobes and stall; cyc/stb/we decode from state only.
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    term_ok    = 1'b0;
    term_err   = 1'b0;
    case (state)
      WB_IDLE: begin
        stall_o = req_valid_i;
        if (req_valid_i) state_next = WB_BUS;
      end
      WB_BUS: begin
        stall_o  = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = we_q;
        // err takes priority over ack; a timeout is handled as an err.
        if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
          term_err   = 1'b1;
          state_next = WB_DONE;
        end else if (wb_ack_i) begin
          term_ok    = 1'b1;
          state_next = WB_DONE;
        end
      end
      WB_DONE: state_next = WB_IDLE;
      default: state_next = WB_IDLE;
    endcase
  end

  // Request capture, timeout counter, load data and error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_word    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      we_q        <= 1'b0;
      rdata_o     <= '0;
      bus_error_o <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (req_valid_i) begin
            adr_word <= req_addr_i[31:2];
            wb_dat_o <= req_wdata_i;
            wb_sel_o <= req_sel_i;
            we_q     <= req_write_i;
            cnt      <= '0;
          end
        end
        WB_BUS: begin
          if (term_err) begin
            rdata_o     <= '0;
            bus_error_o <= 1'b1;
          end else if (term_ok) begin
            if (!we_q) rdata_o <= wb_dat_i;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB_DONE: bus_error_o <= 1'b0;
        default: ;
      endcase
    end
  end

  // Requests are decoded upstream; only the peripheral window may reach here.
  a_window: assert property (@(posedge clk_i) disable iff (rst_i)
    req_valid_i |-> (req_addr_i[31:28] == WB_REGION));

endmodule

// File: tb/tb_rv32_wishbone_master.sv
// Directed bench: load, store, err+ack, timeout, back-to-back and reset-abort.
module tb_rv32_wishbone_master;
  import rv32_wishbone_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid2, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        stall, bus_error, wb_cyc, wb_stb, wb_we;
  logic [31:0] rdata, wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic        wb_ack, wb_err;

  logic        stall2, bus_error2, wb_cyc2, wb_stb2, wb_we2;
  logic [31:0] rdata2, wb_adr2, wb_dat_o2;
  logic [3:0]  wb_sel2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc_starts = 0;
  logic        cyc_prev = 1'b0;

  always #5 clk = ~clk;

  rv32_wishbone_master dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .stall_o(stall), .rdata_o(rdata), .bus_error_o(bus_error),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  rv32_wishbone_master #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(3)) dut_to (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid2), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .stall_o(stall2), .rdata_o(rdata2), .bus_error_o(bus_error2),
    .wb_cyc_o(wb_cyc2), .wb_stb_o(wb_stb2), .wb_we_o(wb_we2), .wb_adr_o(wb_adr2),
    .wb_dat_o(wb_dat_o2), .wb_sel_o(wb_sel2), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  // Count rising edges of wb_cyc on the main instance.
  always @(posedge clk) begin
    if (wb_cyc && !cyc_prev) cyc_starts <= cyc_starts + 1;
    cyc_prev <= wb_cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one access on the main instance starting in IDLE, #2 after an edge.
  // Returns in DONE, 3 time units after the edge, with stall cycles counted.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input logic [31:0] exp_adr,
                            input int unsigned ack_at, input logic use_err,
                            input logic [31:0] dat, output int unsigned stalls);
    int unsigned bus_n;
    bit          done;
    stalls = 0;
    bus_n  = 0;
    done   = 1'b0;
    req_valid = 1'b1; req_write = we; req_addr = addr; req_wdata = wdata; req_sel = sel;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!wb_cyc && bus_n > 0) begin
        done = 1'b1;
        break;
      end
      if (stall) stalls++;
      if (wb_cyc) begin
        bus_n++;
        if (bus_n == 1) begin
          check_eq("bus_adr", wb_adr, exp_adr);
          check_eq("bus_sel", {28'h0, wb_sel}, {28'h0, sel});
          check_eq("bus_we", {31'h0, wb_we}, {31'h0, we});
          check_eq("bus_stb", {31'h0, wb_stb}, 32'h1);
          if (we) check_eq("bus_dat", wb_dat_o, wdata);
        end
        if (bus_n == ack_at) begin
          wb_ack = 1'b1; wb_err = use_err; wb_dat_i = dat;
        end
      end
      @(posedge clk);
      #2;
      wb_ack = 1'b0; wb_err = 1'b0;
    end
    if (!done) check_eq("access_bound", 32'h0, 32'h1);
  endtask

  int unsigned st;
  int unsigned bus2;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_addr = {WB_REGION, 28'h0}; req_wdata = '0; req_sel = '0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    #23;
    check_eq("rst_cyc", {31'h0, wb_cyc}, 32'h0);
    check_eq("rst_stb", {31'h0, wb_stb}, 32'h0);
    check_eq("rst_we", {31'h0, wb_we}, 32'h0);
    check_eq("rst_adr", wb_adr, 32'h0);
    check_eq("rst_dat", wb_dat_o, 32'h0);
    check_eq("rst_sel", {28'h0, wb_sel}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_berr", {31'h0, bus_error}, 32'h0);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Load, ack in 3rd BUS cycle.
    run_access(1'b0, 32'h2000_0008, 32'h0, 4'hF, 32'h2000_0008, 3, 1'b0, 32'hDEAD_BEEF, st);
    req_valid = 1'b0; #1;
    check_eq("ld_stalls", st, 32'd4);
    check_eq("ld_done_stall", {31'h0, stall}, 32'h0);
    check_eq("ld_rdata", rdata, 32'hDEAD_BEEF);
    check_eq("ld_berr", {31'h0, bus_error}, 32'h0);
    @(posedge clk); #2;
    check_eq("ld_rdata_hold", rdata, 32'hDEAD_BEEF);
    check_eq("ld_idle_cyc", {31'h0, wb_cyc}, 32'h0);

    // Store, immediate ack, load data untouched.
    run_access(1'b1, 32'h2000_0013, 32'h0000_AB00, 4'b1000, 32'h2000_0010, 1, 1'b0, 32'h5555_5555, st);
    req_valid = 1'b0; #1;
    check_eq("st_stalls", st, 32'd2);
    check_eq("st_rdata", rdata, 32'hDEAD_BEEF);
    check_eq("st_done_we", {31'h0, wb_we}, 32'h0);
    @(posedge clk); #2;

    // Load terminated with err and ack together.
    run_access(1'b0, 32'h2000_0020, 32'h0, 4'hF, 32'h2000_0020, 2, 1'b1, 32'h1234_5678, st);
    req_valid = 1'b0; #1;
    check_eq("err_rdata", rdata, 32'h0);
    check_eq("err_berr", {31'h0, bus_error}, 32'h1);
    check_eq("err_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #2;
    check_eq("err_berr_clr", {31'h0, bus_error}, 32'h0);
    check_eq("err_idle_cyc", {31'h0, wb_cyc}, 32'h0);

    // Timeout on the 4-cycle instance.
    req_valid2 = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0040; req_sel = 4'hF;
    @(posedge clk); #2;
    bus2 = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wb_cyc2) break;
      bus2++;
      @(posedge clk); #2;
    end
    req_valid2 = 1'b0; #1;
    check_eq("to_bus_cycles", bus2, 32'd4);
    check_eq("to_berr", {31'h0, bus_error2}, 32'h1);
    check_eq("to_stall", {31'h0, stall2}, 32'h0);
    check_eq("to_rdata", rdata2, 32'h0);
    @(posedge clk); #2;
    check_eq("to_berr_clr", {31'h0, bus_error2}, 32'h0);

    // Back-to-back loads with valid held through DONE.
    cyc_starts = 0;
    run_access(1'b0, 32'h2000_0004, 32'h0, 4'hF, 32'h2000_0004, 1, 1'b0, 32'hA5A5_0001, st);
    #1;
    check_eq("b2b_done_stall", {31'h0, stall}, 32'h0);
    check_eq("b2b_done_cyc", {31'h0, wb_cyc}, 32'h0);
    check_eq("b2b_rdata1", rdata, 32'hA5A5_0001);
    @(posedge clk); #2;
    run_access(1'b0, 32'h2000_0004, 32'h0, 4'hF, 32'h2000_0004, 2, 1'b0, 32'hA5A5_0002, st);
    req_valid = 1'b0; #1;
    check_eq("b2b_stalls2", st, 32'd3);
    check_eq("b2b_rdata2", rdata, 32'hA5A5_0002);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check_eq("b2b_cycles", cyc_starts, 32'd2);

    // Reset while BUS is active.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0100; req_sel = 4'hF;
    @(posedge clk); #2;
    check_eq("rb_cyc_before", {31'h0, wb_cyc}, 32'h1);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    check_eq("rb_cyc", {31'h0, wb_cyc}, 32'h0);
    check_eq("rb_stb", {31'h0, wb_stb}, 32'h0);
    check_eq("rb_stall", {31'h0, stall}, 32'h0);
    check_eq("rb_rdata", rdata, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk); #2;
    check_eq("rb_idle_cyc", {31'h0, wb_cyc}, 32'h0);
    run_access(1'b1, 32'h2000_0200, 32'hCAFE_0000, 4'b1100, 32'h2000_0200, 1, 1'b0, 32'h0, st);
    req_valid = 1'b0; #1;
    check_eq("rb_post_stalls", st, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
